// File: rtl/wxyz_acc_check.sv
// ---------------------------------------------------------------------------
// wxyz_acc_check
//   Consumer end of the ABFT checksum accumulator. Each acc_valid pulse
//   delivers one finished w/x/y/z checksum set. Sets are matched in order
//   against expected sets queued on a separate reference stream. The block
//   reports per-lane mismatch, a saturating mismatch count and sticky
//   overflow flags to the fault handler.
//
//   Optional feature: define WXYZ_CHK_SYNDROME_EN to add the w/x/y/z_syn
//   outputs (acc - ref modulo 2^zBits per lane, registered with chk_valid).
//
// Ports
//   clk          clock, all state on the rising edge
//   rst          asynchronous reset, active low
//   acc_valid    1-cycle pulse, w/x/y/z_acc hold a finished checksum set
//   w/x/y/z_acc  accumulated checksums
//   ref_valid    reference push request
//   ref_ready    reference FIFO not full; push accepted on ref_valid&&ref_ready
//   w/x/y/z_ref  expected checksums
//   clear_stat   synchronous clear of err_count, acc_ovf and ref_ovf
//   chk_valid    1-cycle pulse, a comparison result is on err_lane/err_any
//   err_lane     per-lane mismatch {z,y,x,w}, holds until the next result
//   err_any      OR of err_lane, holds until the next result
//   err_count    number of mismatching results, saturates at all-ones
//   acc_ovf      sticky, an accumulated set was dropped
//   ref_ovf      sticky, a reference push was refused
//   w/x/y/z_syn  (WXYZ_CHK_SYNDROME_EN only) per-lane acc - ref
// ---------------------------------------------------------------------------
module wxyz_acc_check #(
   parameter int zBits        = 28,
   parameter int REF_DEPTH    = 4,
   parameter int ERR_CNT_BITS = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    acc_valid,
   input  logic [zBits-1:0]        w_acc,
   input  logic [zBits-1:0]        x_acc,
   input  logic [zBits-1:0]        y_acc,
   input  logic [zBits-1:0]        z_acc,
   input  logic                    ref_valid,
   output logic                    ref_ready,
   input  logic [zBits-1:0]        w_ref,
   input  logic [zBits-1:0]        x_ref,
   input  logic [zBits-1:0]        y_ref,
   input  logic [zBits-1:0]        z_ref,
   input  logic                    clear_stat,
   output logic                    chk_valid,
   output logic [3:0]              err_lane,
   output logic                    err_any,
   output logic [ERR_CNT_BITS-1:0] err_count,
   output logic                    acc_ovf,
   output logic                    ref_ovf
`ifdef WXYZ_CHK_SYNDROME_EN
   ,
   output logic [zBits-1:0]        w_syn,
   output logic [zBits-1:0]        x_syn,
   output logic [zBits-1:0]        y_syn,
   output logic [zBits-1:0]        z_syn
`endif
);

   localparam int AW = $clog2(REF_DEPTH);
   localparam int SW = 4 * zBits;

   // Saturating increment of the mismatch counter.
   function automatic logic [ERR_CNT_BITS-1:0] sat_inc(input logic [ERR_CNT_BITS-1:0] c);
      if (c == {ERR_CNT_BITS{1'b1}})
         return c;
      return c + 1'b1;
   endfunction

   // Lane difference, wraps modulo 2^zBits.
   function automatic logic [zBits-1:0] lane_diff(input logic [zBits-1:0] a,
                                                  input logic [zBits-1:0] b);
      return a - b;
   endfunction

   logic [SW-1:0] live_set;
   logic [SW-1:0] ref_set_in;

   assign live_set   = {z_acc, y_acc, x_acc, w_acc};
   assign ref_set_in = {z_ref, y_ref, x_ref, w_ref};

   // Reference FIFO: pointers carry an extra wrap bit to tell full from empty.
   logic [SW-1:0] fifo_mem [REF_DEPTH];
   logic [AW:0]   wr_ptr;
   logic [AW:0]   rd_ptr;
   logic          fifo_empty;
   logic          fifo_full;
   logic          push;
   logic          ref_drop;

   assign fifo_empty = (wr_ptr == rd_ptr);
   assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign ref_ready  = !fifo_full;
   // Readiness depends on full only, so a full FIFO popping this cycle still refuses.
   assign push       = ref_valid && !fifo_full;
   assign ref_drop   = ref_valid && fifo_full;

   // Pending buffer for an accumulated set still waiting on its reference.
   logic          pend_v;
   logic [SW-1:0] pend_set;

   // ---- stage p0: compare select and lane compare ----
   logic          fire_p0;
   logic [SW-1:0] opnd_p0;
   logic [SW-1:0] ref_head_p0;
   logic [3:0]    lane_err_p0;
   logic          pend_load;
   logic          acc_drop;

   assign fire_p0     = (pend_v || acc_valid) && !fifo_empty;
   assign opnd_p0     = pend_v ? pend_set : live_set;
   assign ref_head_p0 = fifo_mem[rd_ptr[AW-1:0]];

   always_comb begin
      lane_err_p0 = '0;
      for (int i = 0; i < 4; i++)
         lane_err_p0[i] = (opnd_p0[i*zBits +: zBits] != ref_head_p0[i*zBits +: zBits]);
   end

   // A live set goes into pend when it cannot be compared right now and pend is
   // free, or when pend itself is the operand being consumed this cycle.
   assign pend_load = acc_valid && (fire_p0 ? pend_v : !pend_v);
   assign acc_drop  = acc_valid && pend_v && !fire_p0;

   always_ff @(posedge clk) begin
      if (push)
         fifo_mem[wr_ptr[AW-1:0]] <= ref_set_in;
   end

   always_ff @(posedge clk) begin
      if (pend_load)
         pend_set <= live_set;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         pend_v <= 1'b0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (fire_p0)
            rd_ptr <= rd_ptr + 1'b1;
         if (fire_p0)
            pend_v <= pend_v && acc_valid;
         else
            pend_v <= pend_v || acc_valid;
      end
   end

   // ---- stage p1: registered result ----
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         chk_valid <= 1'b0;
         err_lane  <= '0;
         err_any   <= 1'b0;
      end else begin
         chk_valid <= fire_p0;
         if (fire_p0) begin
            err_lane <= lane_err_p0;
            err_any  <= |lane_err_p0;
         end
      end
   end

`ifdef WXYZ_CHK_SYNDROME_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         w_syn <= '0;
         x_syn <= '0;
         y_syn <= '0;
         z_syn <= '0;
      end else if (fire_p0) begin
         w_syn <= lane_diff(opnd_p0[0*zBits +: zBits], ref_head_p0[0*zBits +: zBits]);
         x_syn <= lane_diff(opnd_p0[1*zBits +: zBits], ref_head_p0[1*zBits +: zBits]);
         y_syn <= lane_diff(opnd_p0[2*zBits +: zBits], ref_head_p0[2*zBits +: zBits]);
         z_syn <= lane_diff(opnd_p0[3*zBits +: zBits], ref_head_p0[3*zBits +: zBits]);
      end
   end
`endif

   // Status: clear_stat wins over any coincident increment or overflow event.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         err_count <= '0;
         acc_ovf   <= 1'b0;
         ref_ovf   <= 1'b0;
      end else if (clear_stat) begin
         err_count <= '0;
         acc_ovf   <= 1'b0;
         ref_ovf   <= 1'b0;
      end else begin
         if (chk_valid && err_any)
            err_count <= sat_inc(err_count);
         if (acc_drop)
            acc_ovf <= 1'b1;
         if (ref_drop)
            ref_ovf <= 1'b1;
      end
   end

endmodule
